// File: rtl/mips_pkg.sv
// Shared constants, FSM state encoding and request payload for the data-memory stage.
package mips_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned DEF_ADDR_W  = 6;
  localparam int unsigned DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Payload latched when a legal access is accepted.
  typedef struct packed {
    logic              is_write;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, 2**ADDR_W x 32, registered read, no reset.
// Ports:
//   clk   - clock
//   we    - write enable (writes wdata to mem[addr])
//   re    - read enable (loads mem[addr] into rdata, otherwise rdata holds)
//   addr  - word index
//   wdata - write data
//   rdata - registered read data
module dmem_ram
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage and read register carry no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_stage.sv
// MIPS data-memory stage: checks legality of load/store requests, stalls the
// pipeline for LATENCY busy cycles per access, and muxes the write-back data.
// Ports:
//   Clock    - system clock, rising edge
//   Reset    - asynchronous active-low reset
//   MemRead  - load request
//   MemWrite - store request
//   MemtoReg - write-back select (1 = loaded data, 0 = ALU result)
//   Result   - ALU result / byte address
//   b_data   - store data
//   data     - register-file write-back data (combinational)
//   Stall    - pipeline freeze (combinational)
//   AddrErr  - registered one-cycle illegal-access pulse
module data_mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic [DATA_W-1:0] Result,
  input  logic [DATA_W-1:0] b_data,
  output logic [DATA_W-1:0] data,
  output logic              Stall,
  output logic              AddrErr
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mem_req_t           req_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [DATA_W-1:0]  ram_rdata;
  logic [ADDR_W-1:0]  ram_addr_c;
  logic [ADDR_W-1:0]  idx_c;
  logic               req_c;
  logic               legal_c;
  logic               accept_c;
  logic               finish_c;
  logic               ram_we_c;
  logic               ram_re_c;

  // Legality: one strobe only, word aligned, inside the RAM.
  assign req_c   = MemRead | MemWrite;
  assign legal_c = (MemRead ^ MemWrite) && (Result[1:0] == 2'b00) &&
                   ((Result >> (ADDR_W + 2)) == '0);
  assign idx_c   = Result[ADDR_W+1:2];

  // Next state, counter and stall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    Stall    = 1'b0;
    accept_c = 1'b0;
    finish_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal_c) begin
          Stall    = 1'b1;
          accept_c = 1'b1;
          cnt_d    = CNT_W'(LATENCY - 1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt_q == '0) begin
          finish_c = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The RAM read is launched at acceptance so its registered output is stable
  // by the BUSY->DONE edge; only one access is ever in flight, so no write can
  // intervene. Stores commit only on the BUSY->DONE edge.
  assign ram_re_c   = accept_c & MemRead;
  assign ram_we_c   = finish_c & req_q.is_write;
  assign ram_addr_c = accept_c ? idx_c : idx_q;

  // Control state with asynchronous reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      AddrErr <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      AddrErr <= (state_q == IDLE) && req_c && !legal_c;
      if (finish_c && !req_q.is_write) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  // Request payload; no reset needed since it is only used after acceptance.
  always_ff @(posedge Clock) begin
    if (accept_c) begin
      idx_q          <= idx_c;
      req_q.is_write <= MemWrite;
      req_q.wdata    <= b_data;
    end
  end

  dmem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (Clock),
    .we   (ram_we_c),
    .re   (ram_re_c),
    .addr (ram_addr_c),
    .wdata(req_q.wdata),
    .rdata(ram_rdata)
  );

  // Write-back select.
  assign data = MemtoReg ? rdata_q : Result;

endmodule

// File: tb/tb_data_mem_stage.sv
// Self-checking bench for data_mem_stage: a driver issues instructions and
// pushes per-cycle expectations from a transaction-level memory model; a
// monitor pops and compares on each falling edge.
module tb_data_mem_stage;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic        Clock;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic [31:0] Result;
  logic [31:0] b_data;
  logic [31:0] data;
  logic        Stall;
  logic        AddrErr;

  data_mem_stage #(
    .ADDR_W (ADDR_W),
    .LATENCY(LAT)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .MemRead (MemRead),
    .MemWrite(MemWrite),
    .MemtoReg(MemtoReg),
    .Result  (Result),
    .b_data  (b_data),
    .data    (data),
    .Stall   (Stall),
    .AddrErr (AddrErr)
  );

  typedef struct packed {
    logic        stall;
    logic        aerr;
    logic [31:0] data;
    logic [15:0] id;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          instr_id = 0;
  logic        pend_err;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_rdata;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge Clock);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if (Stall !== mon_e.stall) begin
          errors++;
          $display("FAIL stall instr %0d: got %b want %b", mon_e.id, Stall, mon_e.stall);
        end
        checks++;
        if (AddrErr !== mon_e.aerr) begin
          errors++;
          $display("FAIL addr_err instr %0d: got %b want %b", mon_e.id, AddrErr, mon_e.aerr);
        end
        checks++;
        if (data !== mon_e.data) begin
          errors++;
          $display("FAIL data instr %0d: got %08h want %08h", mon_e.id, data, mon_e.data);
        end
      end
    end
  end

  task automatic push_exp(input logic st, input logic ae, input logic [31:0] d);
    exp_t e;
    e.stall = st;
    e.aerr  = ae;
    e.data  = d;
    e.id    = 16'(instr_id);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // One instruction held on the inputs until the stage releases it.
  task automatic issue(input logic rd, input logic wr, input logic m2r,
                       input logic [31:0] res, input logic [31:0] bd);
    bit legal;
    int idx;
    instr_id++;
    legal = (rd != wr) && (res % 4 == 0) && (res < 32'(4 * DEPTH));
    MemRead  = rd;
    MemWrite = wr;
    MemtoReg = m2r;
    Result   = res;
    b_data   = bd;
    if (legal) begin
      idx = int'(res / 4);
      // Request cycle plus LAT busy cycles stall; access completes into DONE.
      for (int c = 0; c <= int'(LAT); c++) begin
        push_exp(1'b1, pend_err, m2r ? m_rdata : res);
        pend_err = 1'b0;
        step();
      end
      if (wr) m_mem[idx] = bd;
      else    m_rdata = m_mem[idx];
      push_exp(1'b0, 1'b0, m2r ? m_rdata : res);
      step();
    end else begin
      push_exp(1'b0, pend_err, m2r ? m_rdata : res);
      pend_err = rd | wr;
      step();
    end
  endtask

  task automatic random_instr();
    int          kind;
    logic        rd;
    logic [31:0] res;
    kind = int'($urandom_range(0, 9));
    rd   = 1'($urandom_range(0, 1));
    case (kind)
      0, 1, 2: issue(1'b1, 1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1)) * 4, $urandom);
      3, 4, 5: issue(1'b0, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1)) * 4, $urandom);
      6: begin
        res = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        issue(rd, !rd, 1'($urandom_range(0, 1)), res, $urandom);
      end
      7: begin
        if ($urandom_range(0, 1) == 1) res = 32'($urandom_range(DEPTH, 4000)) * 4;
        else res = {8'($urandom_range(1, 255)), 24'h0};
        issue(rd, !rd, 1'($urandom_range(0, 1)), res, $urandom);
      end
      8: issue(1'b1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1)) * 4, $urandom);
      default: issue(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endcase
  endtask

  initial begin
    Reset    = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b1;
    Result   = 32'hA5A5_0001;
    b_data   = 32'h0;
    pend_err = 1'b0;
    m_rdata  = 32'h0;
    step();
    // Reset state: no stall, no error, rdata cleared.
    push_exp(1'b0, 1'b0, 32'h0);
    step();
    MemtoReg = 1'b0;
    push_exp(1'b0, 1'b0, 32'hA5A5_0001);
    step();
    Reset = 1'b1;

    // Fill every word so later loads have defined contents.
    for (int i = 0; i < int'(DEPTH); i++) begin
      issue(1'b0, 1'b1, 1'b0, 32'(i) * 4, $urandom);
    end

    // Store then load.
    issue(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);

    // Misaligned load; following idle cycle shows the pulse and unchanged rdata.
    issue(1'b1, 1'b0, 1'b1, 32'h6, 32'h0);
    issue(1'b0, 1'b0, 1'b1, 32'h6, 32'h0);
    issue(1'b0, 1'b0, 1'b1, 32'h6, 32'h0);

    // Out-of-range store and dual strobe, then read back 0x0 and 0x4.
    issue(1'b0, 1'b1, 1'b0, 32'h100, 32'hBAD0_0001);
    issue(1'b1, 1'b1, 1'b0, 32'h4, 32'hBAD0_0002);
    issue(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);

    // Pass-through.
    issue(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0);

    // Reset in the first busy cycle of a store.
    issue(1'b0, 1'b1, 1'b0, 32'h8, 32'h0);
    instr_id++;
    MemWrite = 1'b1;
    MemRead  = 1'b0;
    MemtoReg = 1'b0;
    Result   = 32'h8;
    b_data   = 32'h1234_5678;
    push_exp(1'b1, pend_err, 32'h8);
    pend_err = 1'b0;
    step();
    Reset    = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b1;
    m_rdata  = 32'h0;
    push_exp(1'b0, 1'b0, 32'h0);
    step();
    Reset = 1'b1;
    issue(1'b1, 1'b0, 1'b1, 32'h8, 32'h0);

    // Back-to-back loads.
    issue(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    issue(1'b1, 1'b0, 1'b1, 32'h4, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      random_instr();
    end
    issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);

    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge Clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_stage.md
DATA_MEM_STAGE -- requirements
Module: data_mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning log2 of memory depth in 32-bit words (64 words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning BUSY cycles per access, legal range 1..15.
REQ-003 SHALL have port Clock, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 SHALL have port MemRead, input, 1, load request from the control unit.
REQ-006 SHALL have port MemWrite, input, 1, store request from the control unit.
REQ-007 SHALL have port MemtoReg, input, 1, write-back select (1 = memory data, 0 = ALU result).
REQ-008 SHALL have port Result, input, 32, ALU result; byte address for loads and stores.
REQ-009 SHALL have port b_data, input, 32, store data (register rt).
REQ-010 SHALL have port data, output, 32, register-file write-back data.
REQ-011 SHALL have port Stall, output, 1, freeze PC and register writes while high.
REQ-012 SHALL have port AddrErr, output, 1, one-cycle pulse flagging an illegal access.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE, with a 4-bit cycle counter cnt.
REQ-014 SHALL, in IDLE, treat a request as legal when exactly one of MemRead/MemWrite is 1, Result[1:0]==0 and Result[31:ADDR_W+2]==0.
REQ-015 SHALL, in IDLE with a legal request: drive Stall=1 combinationally in that cycle, latch word index Result[ADDR_W+1:2], b_data and direction, load cnt=LATENCY-1, go to BUSY.
REQ-016 SHALL, in IDLE with an illegal request (misaligned, out of range, or both strobes high): perform no access, keep Stall=0, register AddrErr=1 for exactly the next cycle, stay in IDLE.
REQ-017 SHALL hold Stall=1 throughout BUSY; decrement cnt each cycle; when cnt==0, issue the RAM access and go to DONE.
REQ-018 SHALL write the latched b_data to the latched word on the BUSY->DONE edge for stores; no other edge writes memory.
REQ-019 SHALL capture RAM read data into register rdata on the BUSY->DONE edge for loads; rdata holds until the next load completes.
REQ-020 SHALL drive Stall=0 in DONE, ignore MemRead/MemWrite in DONE (same instruction still present), and return to IDLE.
REQ-021 SHALL drive data = MemtoReg ? rdata : Result combinationally in all states.
REQ-022 SHALL give total load/store latency of LATENCY+2 cycles from request cycle to first IDLE cycle; back-to-back requests accepted in the IDLE following DONE.
REQ-023 SHALL leave Stall=0 and data=Result for cycles without requests (ALU instructions pass through with zero latency).

Reset
REQ-024 SHALL, while Reset=0, force state=IDLE, cnt=0, rdata=0, AddrErr=0 asynchronously; Stall then follows REQ-015 combinationally.
REQ-025 SHALL abort an in-flight access when Reset asserts in BUSY: no memory write occurs and rdata stays 0.
REQ-026 SHALL NOT reset RAM contents; they are undefined until written.

Structure
REQ-027 SHALL place the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and default ADDR_W/LATENCY constants in shared package mips_pkg.
REQ-028 SHALL instantiate one sub-module dmem_ram: single-port synchronous RAM, 2**ADDR_W x 32, write enable, registered read, no reset.
REQ-029 SHALL keep FSM, counter, legality check and write-back mux in data_mem_stage.

Verification
REQ-030 Store then load: MemWrite=1, Result=0x0000_0010, b_data=0xDEAD_BEEF; then MemRead=1, MemtoReg=1, same address -> Stall high 3 cycles each (LATENCY=2), data=0xDEAD_BEEF in load DONE cycle.
REQ-031 Misaligned: MemRead=1, Result=0x0000_0006 -> AddrErr=1 next cycle only, Stall=0, rdata unchanged.
REQ-032 Out-of-range and dual strobe: MemWrite=1, Result=0x0000_0100; then MemRead=MemWrite=1, Result=0x4 -> AddrErr pulse each, no memory write (read-back of 0x0/0x4 unchanged).
REQ-033 Reset mid-store: MemWrite=1, Result=0x8, b_data=0x1234_5678, Reset=0 in first BUSY cycle -> state IDLE, Stall=0; later load of 0x8 does not return 0x1234_5678 (pre-written 0x0 returned).
REQ-034 Pass-through: MemtoReg=0, no strobes, Result=0xFFFF_FFFE -> data=0xFFFF_FFFE same cycle, Stall=0.
REQ-035 Back-to-back: two loads at 0x0 and 0x4 in consecutive instructions with LATENCY=1 -> second request accepted in IDLE after first DONE, Stall pattern 1,1,0,1,1,0.
